// File: rtl/huffman_seq_ctrl.sv
// Top-level sequencer for the Huffman datapath: sample counting, sort/combine
// stage stepping, backtrack launch and done-wait watchdog.
module huffman_seq_ctrl #(
  parameter int NUM_SAMPLES = 100,
  parameter int NUM_SYM     = 6,
  parameter int SMP_W       = 7,
  parameter int STG_W       = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gray_valid,
  input  logic             sort_done,
  input  logic             bt_done,
  input  logic             restart,
  output logic [SMP_W-1:0] sample_cnt,
  output logic             cnt_valid,
  output logic [STG_W-1:0] stage,
  output logic             sort_start,
  output logic             combine_en,
  output logic             bt_start,
  output logic             code_valid,
  output logic             busy,
  output logic             err
);

  typedef enum logic [3:0] {
    RD_DATA   = 4'd0,
    CNT_OUT   = 4'd1,
    SORT_REQ  = 4'd2,
    SORT_WAIT = 4'd3,
    COMBINE   = 4'd4,
    BT_REQ    = 4'd5,
    BT_WAIT   = 4'd6,
    DONE      = 4'd7,
    ERR       = 4'd8
  } state_t;

  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(NUM_SAMPLES - 1);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_SYM - 2);
  localparam logic [7:0]       WDOG_LIM = 8'(TIMEOUT - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [SMP_W-1:0] cnt_nxt_s;
  logic [STG_W-1:0] stage_nxt_s;
  logic [7:0]       wdog_r;
  logic [7:0]       wdog_nxt_s;
  logic [7:0]       wdog_inc_s;
  logic             timeout_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Watchdog: expires on the cycle its saturating count would reach the limit
  always_comb begin
    wdog_inc_s = sat_inc8(wdog_r);
    timeout_s  = (wdog_inc_s >= WDOG_LIM);
  end

  // Next-state, counter and stage update rules
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = sample_cnt;
    stage_nxt_s = stage;
    wdog_nxt_s  = wdog_r;
    case (state_r)
      RD_DATA: begin
        if (gray_valid) begin
          cnt_nxt_s = sample_cnt + SMP_W'(1'b1);
          if (sample_cnt == LAST_SMP) begin
            state_nxt_s = CNT_OUT;
          end else begin
            state_nxt_s = RD_DATA;
          end
        end else begin
          cnt_nxt_s = sample_cnt;
        end
      end
      CNT_OUT: begin
        stage_nxt_s = {STG_W{1'b0}};
        state_nxt_s = SORT_REQ;
      end
      SORT_REQ: begin
        wdog_nxt_s  = 8'd0;
        state_nxt_s = SORT_WAIT;
      end
      SORT_WAIT: begin
        // A done arriving on the expiry cycle still wins
        if (sort_done) begin
          state_nxt_s = COMBINE;
        end else begin
          wdog_nxt_s = wdog_inc_s;
          if (timeout_s) begin
            state_nxt_s = ERR;
          end else begin
            state_nxt_s = SORT_WAIT;
          end
        end
      end
      COMBINE: begin
        if (stage == LAST_STG) begin
          state_nxt_s = BT_REQ;
        end else begin
          stage_nxt_s = stage + STG_W'(1'b1);
          state_nxt_s = SORT_REQ;
        end
      end
      BT_REQ: begin
        wdog_nxt_s  = 8'd0;
        state_nxt_s = BT_WAIT;
      end
      BT_WAIT: begin
        if (bt_done) begin
          state_nxt_s = DONE;
        end else begin
          wdog_nxt_s = wdog_inc_s;
          if (timeout_s) begin
            state_nxt_s = ERR;
          end else begin
            state_nxt_s = BT_WAIT;
          end
        end
      end
      DONE, ERR: begin
        if (restart) begin
          state_nxt_s = RD_DATA;
          cnt_nxt_s   = {SMP_W{1'b0}};
          stage_nxt_s = {STG_W{1'b0}};
          wdog_nxt_s  = 8'd0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = RD_DATA;
      end
    endcase
  end

  // State/counter registers; outputs registered from the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= RD_DATA;
      sample_cnt <= {SMP_W{1'b0}};
      stage      <= {STG_W{1'b0}};
      wdog_r     <= 8'd0;
      cnt_valid  <= 1'b0;
      sort_start <= 1'b0;
      combine_en <= 1'b0;
      bt_start   <= 1'b0;
      code_valid <= 1'b0;
      busy       <= 1'b1;
      err        <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      sample_cnt <= cnt_nxt_s;
      stage      <= stage_nxt_s;
      wdog_r     <= wdog_nxt_s;
      cnt_valid  <= (state_nxt_s == CNT_OUT);
      sort_start <= (state_nxt_s == SORT_REQ);
      combine_en <= (state_nxt_s == COMBINE);
      bt_start   <= (state_nxt_s == BT_REQ);
      code_valid <= (state_nxt_s == DONE);
      busy       <= (state_nxt_s != DONE) && (state_nxt_s != ERR);
      err        <= (state_nxt_s == ERR);
    end
  end

endmodule

// File: tb/tb_huffman_seq_ctrl.sv
// Self-checking bench for huffman_seq_ctrl: random sample gaps, random done
// latencies and stray handshakes, checked against arithmetic timing expectations.
module tb_huffman_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       gray_valid;
  logic       sort_done;
  logic       bt_done;
  logic       restart;
  logic [6:0] sample_cnt;
  logic       cnt_valid;
  logic [2:0] stage;
  logic       sort_start;
  logic       combine_en;
  logic       bt_start;
  logic       code_valid;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_ss     = 0;
  int n_cb     = 0;
  int n_bt     = 0;
  int model_cnt = 0;

  huffman_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (gray_valid),
    .sort_done  (sort_done),
    .bt_done    (bt_done),
    .restart    (restart),
    .sample_cnt (sample_cnt),
    .cnt_valid  (cnt_valid),
    .stage      (stage),
    .sort_start (sort_start),
    .combine_en (combine_en),
    .bt_start   (bt_start),
    .code_valid (code_valid),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse tallies, used to catch extra or missing handshakes over a run
  always @(negedge clk) begin
    if (sort_start === 1'b1) n_ss++;
    if (combine_en === 1'b1) n_cb++;
    if (bt_start === 1'b1) n_bt++;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic strays(input bit en, input bit sd_ok, input bit bd_ok);
    gray_valid = en ? 1'($urandom) : 1'b0;
    restart    = en ? 1'($urandom) : 1'b0;
    sort_done  = (en && sd_ok) ? 1'($urandom) : 1'b0;
    bt_done    = (en && bd_ok) ? 1'($urandom) : 1'b0;
  endtask

  task automatic clear_inputs;
    gray_valid = 1'b0;
    sort_done  = 1'b0;
    bt_done    = 1'b0;
    restart    = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    clear_inputs();
    repeat (3) tick();
    n_checks++;
    if ({sample_cnt, stage, cnt_valid, sort_start, combine_en, bt_start, code_valid, busy, err}
        !== {7'd0, 3'd0, 7'b0000010}) begin
      n_fail++;
      $display("FAIL reset_values: got cnt=%0d stg=%0d cv=%b ss=%b ce=%b bs=%b code=%b busy=%b err=%b",
               sample_cnt, stage, cnt_valid, sort_start, combine_en, bt_start, code_valid, busy, err);
    end
    reset = 1'b1;
    model_cnt = 0;
  endtask

  task automatic do_restart;
    clear_inputs();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    model_cnt = 0;
    n_checks++;
    if (sample_cnt !== 7'd0 || stage !== 3'd0 || err !== 1'b0 || busy !== 1'b1 || code_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: got cnt=%0d stg=%0d err=%b busy=%b code=%b want 0 0 0 1 0",
               sample_cnt, stage, err, busy, code_valid);
    end
  endtask

  task automatic feed_samples(input int n, input int min_gap, input int max_gap, input bit stray);
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(max_gap, min_gap);
      for (int g = 0; g < gap; g++) begin
        strays(stray, 1'b1, 1'b1);
        gray_valid = 1'b0;
        tick();
        n_checks++;
        if (sample_cnt !== 7'(model_cnt) || cnt_valid !== 1'b0 || err !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_hold: got cnt=%0d cv=%b err=%b want %0d 0 0", sample_cnt, cnt_valid, err, model_cnt);
        end
      end
      strays(stray, 1'b1, 1'b1);
      gray_valid = 1'b1;
      tick();
      model_cnt++;
      n_checks++;
      if (sample_cnt !== 7'(model_cnt) || cnt_valid !== (model_cnt == 100)) begin
        n_fail++;
        $display("FAIL sample_count: got cnt=%0d cv=%b want %0d %b", sample_cnt, cnt_valid, model_cnt, model_cnt == 100);
      end
    end
    clear_inputs();
  endtask

  // Drives the stage/backtrack handshakes; stops after sort_start of stop_at
  task automatic run_stages(input int fixed_wait, input int max_wait, input bit stray, input int stop_at);
    int t0, w, wsum, ss0, cb0, bt0;
    t0 = cyc; wsum = 0; ss0 = n_ss; cb0 = n_cb; bt0 = n_bt;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) strays(stray, 1'b1, 1'b1);
      tick();
      n_checks++;
      if (sort_start !== 1'b1 || stage !== 3'(i) || sample_cnt !== 7'd100 || cnt_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL sort_req: got ss=%b stg=%0d cnt=%0d cv=%b want 1 %0d 100 0", sort_start, stage, sample_cnt, cnt_valid, i);
      end
      if (i == stop_at) return;
      strays(stray, 1'b1, 1'b1);
      tick();
      w = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
      wsum += w;
      for (int k = 0; k < w; k++) begin
        strays(stray, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (combine_en !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
          n_fail++;
          $display("FAIL sort_wait: got ce=%b busy=%b err=%b want 0 1 0", combine_en, busy, err);
        end
      end
      strays(stray, 1'b0, 1'b1);
      sort_done = 1'b1;
      tick();
      n_checks++;
      if (combine_en !== 1'b1 || stage !== 3'(i) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL combine: got ce=%b stg=%0d err=%b want 1 %0d 0", combine_en, stage, err, i);
      end
    end
    strays(stray, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (bt_start !== 1'b1 || stage !== 3'd4) begin
      n_fail++;
      $display("FAIL bt_req: got bs=%b stg=%0d want 1 4", bt_start, stage);
    end
    strays(stray, 1'b1, 1'b1);
    tick();
    w = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
    wsum += w;
    for (int k = 0; k < w; k++) begin
      strays(stray, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (code_valid !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL bt_wait: got code=%b busy=%b err=%b want 0 1 0", code_valid, busy, err);
      end
    end
    strays(stray, 1'b1, 1'b0);
    bt_done = 1'b1;
    tick();
    clear_inputs();
    n_checks++;
    if (code_valid !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL done_state: got code=%b busy=%b err=%b want 1 0 0", code_valid, busy, err);
    end
    n_checks++;
    if (cyc - t0 !== 18 + wsum) begin
      n_fail++;
      $display("FAIL code_latency: got %0d want %0d cycles", cyc - t0, 18 + wsum);
    end
    n_checks++;
    if (n_ss - ss0 !== 5 || n_cb - cb0 !== 5 || n_bt - bt0 !== 1) begin
      n_fail++;
      $display("FAIL pulse_counts: got ss=%0d ce=%0d bs=%0d want 5 5 1", n_ss - ss0, n_cb - cb0, n_bt - bt0);
    end
    tick();
    n_checks++;
    if (code_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold: got code=%b busy=%b want 1 0", code_valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    feed_samples(100, 0, 0, 1'b0);
    run_stages(0, 0, 1'b0, 5);
  endtask

  task automatic test_gapped_samples;
    feed_samples(60, 1, 3, 1'b0);
    feed_samples(40, 1, 3, 1'b0);
    gray_valid = 1'b1;
    run_stages(-1, 4, 1'b0, 5);
  endtask

  task automatic test_timeout;
    int ts;
    bit seen;
    feed_samples(100, 0, 0, 1'b0);
    run_stages(0, 0, 1'b0, 2);
    ts = cyc;
    seen = 1'b0;
    clear_inputs();
    for (int k = 0; k < 300 && !seen; k++) begin
      tick();
      if (err === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || cyc - ts !== 255) begin
      n_fail++;
      $display("FAIL timeout_latency: got seen=%b at %0d cycles want 255", seen, cyc - ts);
    end
    repeat (3) tick();
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || code_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_state: got err=%b busy=%b code=%b want 1 0 0", err, busy, code_valid);
    end
    do_restart();
  endtask

  task automatic test_stray;
    feed_samples(100, 0, 2, 1'b1);
    run_stages(-1, 3, 1'b1, 5);
  endtask

  task automatic test_done_wins;
    feed_samples(100, 0, 0, 1'b0);
    run_stages(253, 0, 1'b0, 5);
  endtask

  task automatic test_reset_midrun;
    feed_samples(100, 0, 1, 1'b0);
    run_stages(0, 0, 1'b0, 3);
    clear_inputs();
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({sample_cnt, stage, cnt_valid, sort_start, combine_en, bt_start, code_valid, busy, err}
        !== {7'd0, 3'd0, 7'b0000010}) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%0d stg=%0d busy=%b err=%b", sample_cnt, stage, busy, err);
    end
    tick();
    reset = 1'b1;
    model_cnt = 0;
    feed_samples(100, 0, 2, 1'b0);
    run_stages(-1, 2, 1'b0, 5);
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_back_to_back();
    do_restart();
    test_gapped_samples();
    do_restart();
    test_timeout();
    test_stray();
    do_restart();
    test_done_wins();
    do_restart();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/huffman_seq_ctrl.md
Name: huffman_seq_ctrl

Overview:
- Top-level sequencer for the Huffman datapath.
- Counts incoming gray samples, then flags when the symbol counts are ready.
- Steps the sort/combine datapath through the NUM_SYM-1 reduction stages (A..E tables for 6 symbols), launches the backtrack, and flags when the code is ready.
- Talks to the sort and backtrack engines through start-pulse/done handshakes; it holds no table data itself.

Parameters:
- NUM_SAMPLES, 100: gray samples per image.
- NUM_SYM, 6: number of symbols; the reduction stage count is NUM_SYM-1.
- SMP_W, 7: sample counter width; must satisfy 2^SMP_W > NUM_SAMPLES.
- STG_W, 3: stage index width.
- TIMEOUT, 255: watchdog limit, in cycles, while waiting for a done.

Ports:
- clk in 1: system clock, rising edge.
- reset in 1: asynchronous, active-low reset.
- gray_valid in 1: one gray sample is present this cycle.
- sort_done in 1: one-cycle pulse; the sort of the current stage has finished.
- bt_done in 1: one-cycle pulse; the backtrack has finished.
- restart in 1: leave DONE or ERR and begin a new image.
- sample_cnt out SMP_W: number of samples accepted so far.
- cnt_valid out 1: one-cycle pulse; CNT1..CNT6 are final.
- stage out STG_W: current reduction stage; 0=A table ... NUM_SYM-2=E table.
- sort_start out 1: one-cycle pulse; start the sort for `stage`.
- combine_en out 1: one-cycle pulse; merge the two smallest entries of `stage` into the next table.
- bt_start out 1: one-cycle pulse; start the backtrack.
- code_valid out 1: level; HC/M outputs are valid.
- busy out 1: high in every state except DONE and ERR.
- err out 1: sticky watchdog error flag.

Behaviour:
- Outputs and reset:
  - All outputs are Moore outputs, decoded from registered state and counters.
  - While reset=0: state=RD_DATA, sample_cnt=0, stage=0, wdog=0, err=0, all pulse outputs 0, code_valid=0, busy=1.
  - Reset asserted mid-operation aborts immediately to these values; no pulse is completed.
- States: RD_DATA, CNT_OUT, SORT_REQ, SORT_WAIT, COMBINE, BT_REQ, BT_WAIT, DONE, ERR.
- RD_DATA:
  - Each cycle with gray_valid=1 increments sample_cnt.
  - When gray_valid=1 and sample_cnt==NUM_SAMPLES-1, sample_cnt becomes NUM_SAMPLES and the next state is CNT_OUT.
  - gray_valid in any other state is ignored; sample_cnt holds.
- CNT_OUT: cnt_valid=1 for exactly this cycle; stage=0; next state SORT_REQ.
- SORT_REQ: sort_start=1 for one cycle; wdog cleared; next state SORT_WAIT.
- SORT_WAIT:
  - sort_done=1 moves to COMBINE.
  - Otherwise wdog increments; when wdog reaches TIMEOUT-1 without sort_done, the next state is ERR.
  - sort_done in the same cycle as the timeout: done wins.
- COMBINE:
  - combine_en=1 for one cycle.
  - If stage==NUM_SYM-2, next state is BT_REQ and stage holds.
  - Otherwise stage increments and the next state is SORT_REQ.
- BT_REQ: bt_start=1 for one cycle; wdog cleared; next state BT_WAIT.
- BT_WAIT: bt_done=1 moves to DONE. Watchdog behaviour is identical to SORT_WAIT.
- DONE: code_valid=1, busy=0. State holds until restart=1.
- ERR: err=1 (sticky), busy=0, code_valid=0. State holds until restart=1.
- restart in DONE or ERR:
  - Next state RD_DATA; sample_cnt, stage, wdog and code_valid are cleared.
  - err clears only on restart or reset.
  - restart in any other state is ignored.
- Stray handshakes: sort_done outside SORT_WAIT and bt_done outside BT_WAIT are ignored. No state change, no error.
- Latency:
  - 100th sample accepted at edge N: cnt_valid high in cycle N+1, sort_start high in N+2.
  - Each stage costs 1 (SORT_REQ) + wait + 1 (COMBINE) cycles. The earliest sort_done is the cycle after sort_start.
  - With zero-wait dones, the full run from cnt_valid to code_valid is 1 + 5*3 + 2 = 18 cycles for NUM_SYM=6.
- Widths: wdog is 8 bits and saturates; it does not wrap. stage never exceeds NUM_SYM-2.

Test Plan:
- Reset, then 100 consecutive gray_valid pulses → sample_cnt reads 1..100; cnt_valid pulses exactly once, one cycle after the 100th sample; sort_start follows one cycle later with stage=0.
- 60 samples with gaps of 1-3 idle cycles, then 40 more → cnt_valid fires only after sample 100; a gray_valid on the cycle after cnt_valid leaves sample_cnt at 100.
- Model that returns sort_done 1 cycle after each sort_start and bt_done 1 cycle after bt_start → 5 sort_start and 5 combine_en pulses with stage=0,1,2,3,4; one bt_start; code_valid rises 18 cycles after cnt_valid; busy falls with it.
- sort_done held low at stage 2 → err=1 and the state reaches ERR 255 cycles after sort_start; code_valid stays 0; restart returns to RD_DATA with stage=0, sample_cnt=0 and err=0.
- Stray sort_done during RD_DATA and BT_WAIT, and a stray bt_done during SORT_WAIT → no state change and no err; the sequence completes normally.
- reset driven low while in SORT_WAIT at stage 3, then released → all outputs return to reset values at once; a fresh run of 100 samples completes correctly.
